// File: rtl/store_fwd_unit.sv
// -----------------------------------------------------------------------------
// store_fwd_unit
//
// Store-data forwarding and load-use interlock for the MEM stage. An outgoing
// store names its data register (rt). This block resolves that register
// against the write in flight this cycle, a short history of recent register
// writes, and one outstanding load. It returns the forwarded value, or holds
// the store off while the load it depends on is still in flight.
//
// Parameters
//   REG_W   register-address width; register 0 is never recorded or forwarded
//   DATA_W  data width
//   DEPTH   write-history entries, youngest is entry 0 (2..8)
//   CNT_W   performance-counter width
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   flush                pipeline flush: clears history, pending load and FSM
//   wr_en/wr_reg/wr_data register write this cycle
//   ld_issue/ld_reg      load issued; its data returns later on ld_ret
//   ld_ret/ld_ret_data   pending load data valid this cycle
//   st_valid/st_reg      store requests its data register
//   st_ready             store accepted this cycle (0 = stall)
//   fwd_hit/fwd_data     forwarded value replaces the register-file value
//   ld_busy              a load is pending
//   stalled              FSM is in STALL (registered)
//   fwd_cnt/stall_cnt    saturating counts of forwarded stores / hazard cycles
// -----------------------------------------------------------------------------
module store_fwd_unit #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [REG_W-1:0]  wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ld_issue,
  input  logic [REG_W-1:0]  ld_reg,
  input  logic              ld_ret,
  input  logic [DATA_W-1:0] ld_ret_data,
  input  logic              st_valid,
  input  logic [REG_W-1:0]  st_reg,
  output logic              st_ready,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              ld_busy,
  output logic              stalled,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {IDLE, STALL} stateE;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // Saturating increment shared by both performance counters.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State
  logic              histV    [DEPTH];
  logic [REG_W-1:0]  histReg  [DEPTH];
  logic [DATA_W-1:0] histData [DEPTH];
  logic              pendV;
  logic [REG_W-1:0]  pendReg;
  stateE             state;
  logic [CNT_W-1:0]  fwdCnt;
  logic [CNT_W-1:0]  stallCnt;

  // Next-state values
  logic              midV     [DEPTH];
  logic [REG_W-1:0]  midReg   [DEPTH];
  logic [DATA_W-1:0] midData  [DEPTH];
  logic              nextV    [DEPTH];
  logic [REG_W-1:0]  nextReg  [DEPTH];
  logic [DATA_W-1:0] nextData [DEPTH];
  logic              pendVNext;
  logic [REG_W-1:0]  pendRegNext;
  stateE             stateNext;

  // Combinational decode
  logic              wrInsert;
  logic              ldInsert;
  logic              pendMatch;
  logic              hazard;
  logic              lookupEn;
  logic              fwdHitC;
  logic [DATA_W-1:0] fwdDataC;

  assign wrInsert  = wr_en && (wr_reg != ZERO_REG);
  assign ldInsert  = ld_ret && pendV;
  assign pendMatch = pendV && (pendReg == st_reg);

  // A store stalls only on the pending load's register, and only while that
  // load has not returned this cycle; flush always releases the store.
  assign hazard   = st_valid && (st_reg != ZERO_REG) && pendMatch && !ld_ret && !flush;
  assign lookupEn = st_valid && !hazard && !flush && (st_reg != ZERO_REG);

  // ---- Forward lookup (zero latency) ----
  always_comb begin
    fwdHitC  = 1'b0;
    fwdDataC = '0;
    if (lookupEn) begin
      if (ld_ret && pendMatch) begin
        fwdHitC  = 1'b1;
        fwdDataC = ld_ret_data;
      end else if (wr_en && (wr_reg == st_reg)) begin
        fwdHitC  = 1'b1;
        fwdDataC = wr_data;
      end else begin
        // Scan oldest to youngest so the youngest match is the one that sticks.
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (histV[i] && (histReg[i] == st_reg)) begin
            fwdHitC  = 1'b1;
            fwdDataC = histData[i];
          end
        end
      end
    end
  end

  // ---- History next state ----
  // The returning load is inserted first and the register write second, so
  // when both happen in one cycle the write lands in entry 0 as the youngest.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      midV[i]    = histV[i];
      midReg[i]  = histReg[i];
      midData[i] = histData[i];
    end
    if (ldInsert) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        midV[i]    = histV[i-1];
        midReg[i]  = histReg[i-1];
        midData[i] = histData[i-1];
      end
      midV[0]    = 1'b1;
      midReg[0]  = pendReg;
      midData[0] = ld_ret_data;
    end

    for (int i = 0; i < DEPTH; i++) begin
      nextV[i]    = midV[i];
      nextReg[i]  = midReg[i];
      nextData[i] = midData[i];
    end
    if (wrInsert) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        nextV[i]    = midV[i-1];
        nextReg[i]  = midReg[i-1];
        nextData[i] = midData[i-1];
      end
      nextV[0]    = 1'b1;
      nextReg[0]  = wr_reg;
      nextData[0] = wr_data;
    end
  end

  // ---- Pending-load next state ----
  // A new load may replace the pending one only in the cycle the old one
  // returns; an issue while still pending is dropped.
  always_comb begin
    pendVNext   = pendV;
    pendRegNext = pendReg;
    if (flush) begin
      pendVNext = 1'b0;
    end else if (ld_issue && (ld_reg != ZERO_REG) && (!pendV || ld_ret)) begin
      pendVNext   = 1'b1;
      pendRegNext = ld_reg;
    end else if (ld_ret) begin
      pendVNext = 1'b0;
    end
  end

  // ---- FSM next state ----
  // hazard already folds in flush and ld_ret, so dropping it covers every
  // exit from STALL.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (hazard)  stateNext = STALL;
      STALL:   if (!hazard) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---- Control registers (reset) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) histV[i] <= 1'b0;
      pendV    <= 1'b0;
      state    <= IDLE;
      fwdCnt   <= '0;
      stallCnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) histV[i] <= flush ? 1'b0 : nextV[i];
      pendV <= pendVNext;
      state <= stateNext;
      if (fwdHitC) fwdCnt   <= satInc(fwdCnt);
      if (hazard)  stallCnt <= satInc(stallCnt);
    end
  end

  // ---- Data registers (no reset; qualified by the valids above) ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      histReg[i]  <= nextReg[i];
      histData[i] <= nextData[i];
    end
    pendReg <= pendRegNext;
  end

  // ---- Outputs ----
  assign st_ready  = !hazard;
  assign fwd_hit   = fwdHitC;
  assign fwd_data  = fwdDataC;
  assign ld_busy   = pendV;
  assign stalled   = (state == STALL);
  assign fwd_cnt   = fwdCnt;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_store_fwd_unit.sv
module tb_store_fwd_unit;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;   // narrow so saturation is reachable quickly

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              wr_en;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              ld_issue;
  logic [REG_W-1:0]  ld_reg;
  logic              ld_ret;
  logic [DATA_W-1:0] ld_ret_data;
  logic              st_valid;
  logic [REG_W-1:0]  st_reg;
  logic              st_ready;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              ld_busy;
  logic              stalled;
  logic [CNT_W-1:0]  fwd_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  store_fwd_unit #(.REG_W(REG_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .ld_issue(ld_issue), .ld_reg(ld_reg),
    .ld_ret(ld_ret), .ld_ret_data(ld_ret_data),
    .st_valid(st_valid), .st_reg(st_reg),
    .st_ready(st_ready), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .ld_busy(ld_busy), .stalled(stalled),
    .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string             tag;
    logic              stReady;
    logic              fwdHit;
    logic [DATA_W-1:0] fwdData;
    logic              ldBusy;
    logic              stalled;
    logic [CNT_W-1:0]  fwdCnt;
    logic [CNT_W-1:0]  stallCnt;
  } expT;

  expT sb[$];
  int nAssert = 0;
  int nFail   = 0;
  logic [CNT_W-1:0] fwdTally;
  logic [CNT_W-1:0] stallTally;

  function automatic logic [CNT_W-1:0] satUp(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    flush = 0; wr_en = 0; wr_reg = 0; wr_data = 0;
    ld_issue = 0; ld_reg = 0; ld_ret = 0; ld_ret_data = 0;
    st_valid = 0; st_reg = 0;
  endtask

  // Push this cycle's expectation, sample at the falling edge, then advance
  // to just after the next rising edge. Counter expectations are the tallies
  // accumulated from earlier cycles.
  task automatic step(input string tag, input logic eReady, input logic eHit,
                      input logic [DATA_W-1:0] eData, input logic eBusy, input logic eStalled);
    expT e;
    expT got;
    e.tag = tag; e.stReady = eReady; e.fwdHit = eHit; e.fwdData = eData;
    e.ldBusy = eBusy; e.stalled = eStalled; e.fwdCnt = fwdTally; e.stallCnt = stallTally;
    sb.push_back(e);
    if (st_valid && eReady && eHit) fwdTally = satUp(fwdTally);
    if (!eReady) stallTally = satUp(stallTally);
    @(negedge clk);
    if (sb.size() == 0) begin
      nFail++;
      $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      got = sb.pop_front();
      chk({got.tag, ".st_ready"},  {{(DATA_W-1){1'b0}}, st_ready}, {{(DATA_W-1){1'b0}}, got.stReady});
      chk({got.tag, ".fwd_hit"},   {{(DATA_W-1){1'b0}}, fwd_hit},  {{(DATA_W-1){1'b0}}, got.fwdHit});
      chk({got.tag, ".fwd_data"},  fwd_data, got.fwdData);
      chk({got.tag, ".ld_busy"},   {{(DATA_W-1){1'b0}}, ld_busy},  {{(DATA_W-1){1'b0}}, got.ldBusy});
      chk({got.tag, ".stalled"},   {{(DATA_W-1){1'b0}}, stalled},  {{(DATA_W-1){1'b0}}, got.stalled});
      chk({got.tag, ".fwd_cnt"},   {{(DATA_W-CNT_W){1'b0}}, fwd_cnt},   {{(DATA_W-CNT_W){1'b0}}, got.fwdCnt});
      chk({got.tag, ".stall_cnt"}, {{(DATA_W-CNT_W){1'b0}}, stall_cnt}, {{(DATA_W-CNT_W){1'b0}}, got.stallCnt});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fwdTally = 0; stallTally = 0;
    rst_n = 0;
    clearIn();
    step("reset", 1, 0, 0, 0, 0);
    rst_n = 1;

    // Forward from history one cycle after the write
    clearIn(); wr_en = 1; wr_reg = 5; wr_data = 32'hA;
    step("t1_wr", 1, 0, 0, 0, 0);
    clearIn(); st_valid = 1; st_reg = 5;
    step("t1_st", 1, 1, 32'hA, 0, 0);
    clearIn();
    step("t1_cnt", 1, 0, 0, 0, 0);

    // Same-cycle bypass beats older history
    clearIn(); wr_en = 1; wr_reg = 7; wr_data = 32'h22;
    step("t2_wr22", 1, 0, 0, 0, 0);
    clearIn(); wr_en = 1; wr_reg = 7; wr_data = 32'h11; st_valid = 1; st_reg = 7;
    step("t2_bypass", 1, 1, 32'h11, 0, 0);
    clearIn(); st_valid = 1; st_reg = 7;
    step("t2_youngest", 1, 1, 32'h11, 0, 0);

    // Load-use stall and release on return
    clearIn(); ld_issue = 1; ld_reg = 9;
    step("t3_issue", 1, 0, 0, 0, 0);
    clearIn(); st_valid = 1; st_reg = 9;
    step("t3_stall1", 0, 0, 0, 1, 0);
    step("t3_stall2", 0, 0, 0, 1, 1);
    step("t3_stall3", 0, 0, 0, 1, 1);
    ld_ret = 1; ld_ret_data = 32'hBEEF;
    step("t3_ret", 1, 1, 32'hBEEF, 1, 1);
    clearIn();
    step("t3_after", 1, 0, 0, 0, 0);
    st_valid = 1; st_reg = 9;
    step("t3_histld", 1, 1, 32'hBEEF, 0, 0);

    // Register 0 never recorded, forwarded or made pending
    clearIn(); wr_en = 1; wr_reg = 0; wr_data = 32'h55; st_valid = 1; st_reg = 0;
    step("t4_r0", 1, 0, 0, 0, 0);
    clearIn(); ld_issue = 1; ld_reg = 0;
    step("t4_ldr0", 1, 0, 0, 0, 0);
    clearIn();
    step("t4_busy", 1, 0, 0, 0, 0);

    // Eviction at DEPTH=2
    clearIn(); wr_en = 1; wr_reg = 1; wr_data = 32'h101;
    step("t5_w1", 1, 0, 0, 0, 0);
    wr_reg = 2; wr_data = 32'h102;
    step("t5_w2", 1, 0, 0, 0, 0);
    wr_reg = 3; wr_data = 32'h103;
    step("t5_w3", 1, 0, 0, 0, 0);
    clearIn(); st_valid = 1; st_reg = 1;
    step("t5_evict", 1, 0, 0, 0, 0);
    st_reg = 2;
    step("t5_keep", 1, 1, 32'h102, 0, 0);

    // Flush during stall
    clearIn(); ld_issue = 1; ld_reg = 4;
    step("t6_issue", 1, 0, 0, 0, 0);
    clearIn(); st_valid = 1; st_reg = 4;
    step("t6_stall1", 0, 0, 0, 1, 0);
    step("t6_stall2", 0, 0, 0, 1, 1);
    flush = 1; wr_en = 1; wr_reg = 6; wr_data = 32'h66;
    step("t6_flush", 1, 0, 0, 1, 1);
    clearIn();
    step("t6_after", 1, 0, 0, 0, 0);
    st_valid = 1; st_reg = 2;
    step("t6_empty2", 1, 0, 0, 0, 0);
    st_reg = 6;
    step("t6_empty6", 1, 0, 0, 0, 0);

    // stall_cnt saturation
    clearIn(); ld_issue = 1; ld_reg = 8;
    step("sat_issue", 1, 0, 0, 0, 0);
    clearIn(); st_valid = 1; st_reg = 8;
    for (int i = 0; i < 12; i++) step("sat_stall", 0, 0, 0, 1, (i > 0));
    step("sat_hold", 0, 0, 0, 1, 1);
    nAssert++;
    assert (stall_cnt === {CNT_W{1'b1}}) else begin
      nFail++;
      $error("FAIL sat_allones observed=%0h expected=%0h", stall_cnt, {CNT_W{1'b1}});
    end

    // Asynchronous reset mid-stall: outputs return to reset values at once
    rst_n = 0; fwdTally = 0; stallTally = 0;
    step("rst_mid", 1, 0, 0, 0, 0);
    rst_n = 1;
    clearIn(); ld_ret = 1; ld_ret_data = 32'h1234; st_valid = 1; st_reg = 8;
    step("rst_lostret", 1, 0, 0, 0, 0);
    clearIn(); st_valid = 1; st_reg = 9;
    step("rst_histgone", 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
